// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: M0 (pipeline) has priority,
// M1 (DMA/loader/debug) is protected from starvation. One access per grant, 2-cycle latency.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_type,
  input  logic [31:0] m0_pc,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_type,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        cmd_we_q, cmd_we_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [2:0]  cmd_type_q, cmd_type_d;
  logic [31:0] cmd_pc_q, cmd_pc_d;
  logic        cmd_owner_q, cmd_owner_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [3:0]  starve_q, starve_d;

  logic arb_open, m0_win, m1_win, bad, rsp_valid;

  // Arbitration is open in IDLE and RESP, never while reset is asserted.
  assign arb_open = (state_q != StAccess) && !reset;
  assign m1_win   = arb_open && m1_req && (!m0_req || (starve_q == StarveMax));
  assign m0_win   = arb_open && m0_req && !m1_win;

  assign bad = ((cmd_type_q == 3'd0) && (cmd_addr_q[1:0] != 2'b00)) ||
               (((cmd_type_q == 3'd1) || (cmd_type_q == 3'd2)) && cmd_addr_q[0]) ||
               (cmd_type_q > 3'd4);

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_type_d  = cmd_type_q;
    cmd_pc_d    = cmd_pc_q;
    cmd_owner_d = cmd_owner_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      StIdle, StResp: begin
        if (m0_win || m1_win) begin
          cmd_owner_d = m1_win;
          cmd_we_d    = m1_win ? m1_we    : m0_we;
          cmd_addr_d  = m1_win ? m1_addr  : m0_addr;
          cmd_wdata_d = m1_win ? m1_wdata : m0_wdata;
          cmd_type_d  = m1_win ? m1_type  : m0_type;
          cmd_pc_d    = m1_win ? 32'h0    : m0_pc;
          state_d     = StAccess;
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        rsp_data_d = (cmd_we_q || bad) ? 32'h0 : mem_rd;
        rsp_err_d  = bad;
        state_d    = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!m1_req || m1_win) begin
      starve_d = 4'd0;
    end else if (m0_win && (starve_q < StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= 32'h0;
      cmd_wdata_q <= 32'h0;
      cmd_type_q  <= 3'd0;
      cmd_pc_q    <= 32'h0;
      cmd_owner_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_type_q  <= cmd_type_d;
      cmd_pc_q    <= cmd_pc_d;
      cmd_owner_q <= cmd_owner_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      starve_q    <= starve_d;
    end
  end

  assign m0_gnt = m0_win;
  assign m1_gnt = m1_win;

  // Reset kills both the pending write and the pending response in the same cycle.
  assign rsp_valid = (state_q == StResp) && !reset;
  assign m0_rvalid = rsp_valid && !cmd_owner_q;
  assign m1_rvalid = rsp_valid && cmd_owner_q;
  assign m0_rdata  = m0_rvalid ? rsp_data_q : 32'h0;
  assign m1_rdata  = m1_rvalid ? rsp_data_q : 32'h0;
  assign m0_err    = m0_rvalid && rsp_err_q;
  assign m1_err    = m1_rvalid && rsp_err_q;

  assign mem_we   = (state_q == StAccess) && cmd_we_q && !bad && !reset;
  assign mem_a    = cmd_addr_q;
  assign mem_wd   = cmd_wdata_q;
  assign mem_type = cmd_type_q;
  assign mem_pc   = cmd_pc_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single transactions against a small memory
// model, plus hand-written starvation, back-to-back and reset-in-access sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata;
  logic [2:0]  m0_type, m1_type;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_pc, mem_rd;
  logic [2:0]  mem_type;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_type(m0_type), .m0_pc(m0_pc), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_type(m1_type), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_type(mem_type),
    .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  // Little-endian data memory model; does its own lane select and extension by type.
  logic [31:0] mem [0:15];
  logic [31:0] word, shifted, wr_word, lane_mask;
  always_comb begin
    word    = mem[mem_a[5:2]];
    shifted = word >> (5'(mem_a[1:0]) * 5'd8);
    case (mem_type)
      3'd1:    mem_rd = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    mem_rd = {16'h0, shifted[15:0]};
      3'd3:    mem_rd = {{24{shifted[7]}}, shifted[7:0]};
      3'd4:    mem_rd = {24'h0, shifted[7:0]};
      default: mem_rd = word;
    endcase
    case (mem_type)
      3'd1, 3'd2: lane_mask = 32'h0000FFFF << (5'(mem_a[1:0]) * 5'd8);
      3'd3, 3'd4: lane_mask = 32'h000000FF << (5'(mem_a[1:0]) * 5'd8);
      default:    lane_mask = 32'hFFFFFFFF;
    endcase
    wr_word = (word & ~lane_mask) | ((mem_wd << (5'(mem_a[1:0]) * 5'd8)) & lane_mask);
  end
  always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= wr_word;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
    logic [31:0] pc;
    logic        exp_we;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] typ,
                              input logic exp_we, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.typ = typ;
    v.pc = 32'h1000 + addr; v.exp_we = exp_we; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_type = 0; m0_pc = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_type = 0;
  endtask

  // Called just after a posedge; returns just after the posedge following RESP.
  task automatic run_txn(input vec_t v, input string tag);
    logic got = 0;
    m0_pc = v.pc;
    if (v.port) begin
      m1_req = 1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_type = v.typ;
    end else begin
      m0_req = 1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_type = v.typ;
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      got = v.port ? m1_gnt : m0_gnt;
      if (got) break;
    end
    check({tag, " gnt"}, 32'(got), 32'd1);
    check({tag, " other gnt"}, 32'(v.port ? m0_gnt : m1_gnt), 32'd0);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    check({tag, " mem_we"}, 32'(mem_we), 32'(v.exp_we));
    check({tag, " mem_a"}, mem_a, v.addr);
    check({tag, " mem_pc"}, mem_pc, v.port ? 32'h0 : v.pc);
    @(negedge clk);
    check({tag, " rvalid"}, 32'(v.port ? m1_rvalid : m0_rvalid), 32'd1);
    check({tag, " other rvalid"}, 32'(v.port ? m0_rvalid : m1_rvalid), 32'd0);
    check({tag, " rdata"}, v.port ? m1_rdata : m0_rdata, v.exp_rdata);
    check({tag, " err"}, 32'(v.port ? m1_err : m0_err), 32'(v.exp_err));
    @(posedge clk); #1;
  endtask

  vec_t vecs [16];
  int   exp_seq [12] = '{1, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1, 0};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(0, 1, 32'h10, 32'hDEADBEEF, 3'd0, 1, 32'h0,        0); // sw
    vecs[1]  = mk(0, 0, 32'h10, 32'h0,        3'd0, 0, 32'hDEADBEEF, 0); // lw
    vecs[2]  = mk(1, 1, 32'h10, 32'h80FF1234, 3'd0, 1, 32'h0,        0); // M1 sw
    vecs[3]  = mk(0, 0, 32'h13, 32'h0,        3'd3, 0, 32'hFFFFFF80, 0); // lb
    vecs[4]  = mk(0, 0, 32'h13, 32'h0,        3'd4, 0, 32'h00000080, 0); // lbu
    vecs[5]  = mk(0, 0, 32'h12, 32'h0,        3'd1, 0, 32'hFFFF80FF, 0); // lh
    vecs[6]  = mk(0, 0, 32'h10, 32'h0,        3'd2, 0, 32'h00001234, 0); // lhu
    vecs[7]  = mk(1, 1, 32'h12, 32'h11111111, 3'd0, 0, 32'h0,        1); // misaligned sw
    vecs[8]  = mk(1, 1, 32'h10, 32'h22222222, 3'd5, 0, 32'h0,        1); // illegal type
    vecs[9]  = mk(0, 0, 32'h10, 32'h0,        3'd0, 0, 32'h80FF1234, 0); // unchanged
    vecs[10] = mk(0, 1, 32'h11, 32'h3333,     3'd1, 0, 32'h0,        1); // misaligned sh
    vecs[11] = mk(0, 0, 32'h11, 32'h0,        3'd0, 0, 32'h0,        1); // misaligned lw
    vecs[12] = mk(1, 1, 32'h11, 32'h000000AB, 3'd3, 1, 32'h0,        0); // sb
    vecs[13] = mk(1, 0, 32'h10, 32'h0,        3'd0, 0, 32'h80FFAB34, 0); // lw after sb
    vecs[14] = mk(1, 1, 32'h00, 32'h01020304, 3'd0, 1, 32'h0,        0);
    vecs[15] = mk(1, 1, 32'h04, 32'hA5A5A5A5, 3'd0, 1, 32'h0,        0);

    // Reset: requests present but nothing may be granted.
    idle_inputs();
    reset = 1; m0_req = 1; m1_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset m0_gnt", 32'(m0_gnt), 32'd0);
    check("reset m1_gnt", 32'(m1_gnt), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_a", mem_a, 32'h0);
    check("reset rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0; reset = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Both ports requesting continuously: M1 wins after four M0 grants.
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_type = 3'd0; m0_pc = 32'h200;
    m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'h80FFAB34; m1_type = 3'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("starve gnt c%0d", c), 32'({m1_gnt, m0_gnt}), 32'(exp_seq[c]));
      if (c == 1) check("starve m0 mem_pc", mem_pc, 32'h200);
      if (c == 9) begin
        check("starve m1 mem_pc", mem_pc, 32'h0);
        check("starve m1 mem_we", 32'(mem_we), 32'd1);
      end
      if (c == 10) check("starve m1 rvalid", 32'(m1_rvalid), 32'd1);
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk); #1;

    // Back-to-back M0 loads with req held: second grant lands on the first rvalid.
    m0_req = 1; m0_we = 0; m0_addr = 32'h0; m0_type = 3'd0; m0_pc = 32'h300;
    @(negedge clk);
    check("b2b gnt0", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;
    m0_addr = 32'h4;
    @(negedge clk);
    check("b2b c1 gnt", 32'(m0_gnt), 32'd0);
    @(negedge clk);
    check("b2b rvalid0", 32'(m0_rvalid), 32'd1);
    check("b2b rdata0", m0_rdata, 32'h01020304);
    check("b2b gnt1", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    check("b2b c3 rvalid", 32'(m0_rvalid), 32'd0);
    @(negedge clk);
    check("b2b rvalid1", 32'(m0_rvalid), 32'd1);
    check("b2b rdata1", m0_rdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    idle_inputs();

    // Reset asserted during the ACCESS cycle of an M0 store.
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'h55555555; m0_pc = 32'h400;
    @(negedge clk);
    check("rst-acc gnt", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;
    m0_req = 0; reset = 1;
    @(negedge clk);
    check("rst-acc mem_we", 32'(mem_we), 32'd0);
    check("rst-acc rvalid", 32'(m0_rvalid), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("rst-acc post rvalid", 32'(m0_rvalid), 32'd0);
    check("rst-acc post mem_a", mem_a, 32'h0);
    check("rst-acc post mem_wd", mem_wd, 32'h0);
    check("rst-acc post mem_pc", mem_pc, 32'h0);
    check("rst-acc post mem_type", 32'(mem_type), 32'd0);
    check("rst-acc post rdata", m0_rdata, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    run_txn(mk(0, 0, 32'h10, 32'h0, 3'd0, 0, 32'h80FFAB34, 0), "rst-acc memory");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
